// File: rtl/q_enc_velocity.sv
// Quadrature encoder velocity estimator: samples position once per PERIOD-clock window
// and reports the saturated count delta between consecutive samples.
module q_enc_velocity #(
  parameter int PERIOD = 50000,
  parameter int VEL_W  = 16
) (
  input  logic                    clock,
  input  logic                    sclr,
  input  logic                    ena,
  input  logic signed [31:0]      position,
  input  logic                    pos_error,
  output logic signed [VEL_W-1:0] velocity,
  output logic                    vel_valid,
  output logic                    sample_err,
  output logic                    overflow
);

  localparam int                  CNT_W = $clog2(PERIOD);
  localparam logic [CNT_W-1:0]    LAST  = CNT_W'(PERIOD - 1);
  localparam longint              VMAX  = (longint'(1) <<< (VEL_W - 1)) - 1;
  localparam longint              VMIN  = -(longint'(1) <<< (VEL_W - 1));

  typedef enum logic {PRIME, RUN} state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic                   tick;
  logic                   err_latch;
  logic signed [31:0]     prev_pos;
  logic signed [31:0]     delta_p0;
  logic                   vld_p0;
  logic                   err_p0;

  function automatic logic sat_clipped(input logic signed [31:0] d);
    return (longint'(d) > VMAX) || (longint'(d) < VMIN);
  endfunction

  function automatic logic signed [VEL_W-1:0] sat(input logic signed [31:0] d);
    if (longint'(d) > VMAX)      return VEL_W'(VMAX);
    else if (longint'(d) < VMIN) return VEL_W'(VMIN);
    else                         return VEL_W'(d);
  endfunction

  assign tick = ena && (cnt == LAST);

  always_comb begin
    state_nxt = state;
    if (tick) state_nxt = RUN;
  end

  // Window counter, state and error latch; a tick-cycle error belongs to the ending window
  always_ff @(posedge clock) begin
    if (sclr) begin
      cnt       <= '0;
      state     <= PRIME;
      err_latch <= 1'b0;
    end else begin
      state <= state_nxt;
      if (ena) cnt <= tick ? '0 : cnt + 1'b1;
      if (tick)           err_latch <= 1'b0;
      else if (pos_error) err_latch <= 1'b1;
    end
  end

  // Stage p0: sample position on the tick edge; modulo-2^32 subtraction absorbs counter wrap
  always_ff @(posedge clock) begin
    if (sclr) begin
      prev_pos <= '0;
      delta_p0 <= '0;
      vld_p0   <= 1'b0;
      err_p0   <= 1'b0;
    end else begin
      vld_p0 <= tick && (state == RUN);
      if (tick) begin
        prev_pos <= position;
        err_p0   <= err_latch | pos_error;
        if (state == RUN) delta_p0 <= position - prev_pos;
      end
    end
  end

  // Stage p1: saturate and publish; independent of ena so an in-flight sample completes
  always_ff @(posedge clock) begin
    if (sclr) begin
      velocity   <= '0;
      vel_valid  <= 1'b0;
      sample_err <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      vel_valid <= vld_p0;
      if (vld_p0) begin
        velocity   <= sat(delta_p0);
        sample_err <= err_p0;
        if (sat_clipped(delta_p0)) overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_q_enc_velocity.sv
// Self-checking bench for q_enc_velocity with a window-level behavioural model.
module tb_q_enc_velocity;
  localparam int     PERIOD = 4;
  localparam int     VEL_W  = 8;
  localparam longint VMAX   = (longint'(1) <<< (VEL_W - 1)) - 1;
  localparam longint VMIN   = -(longint'(1) <<< (VEL_W - 1));

  logic                    clock = 1'b0;
  logic                    sclr, ena, pos_error;
  logic signed [31:0]      position;
  logic signed [VEL_W-1:0] velocity;
  logic                    vel_valid, sample_err, overflow;

  int checks = 0;
  int errors = 0;

  // Model: window position bookkeeping plus what the outputs show after each edge
  int                      m_cnt;
  bit                      m_run;
  logic signed [31:0]      m_prev;
  bit                      m_err_win;
  bit                      p_vld, p_err, p_ovf;
  logic signed [VEL_W-1:0] p_vel;
  bit                      m_vv, m_serr, m_ovf;
  logic signed [VEL_W-1:0] m_vel;

  q_enc_velocity #(.PERIOD(PERIOD), .VEL_W(VEL_W)) dut (
    .clock(clock), .sclr(sclr), .ena(ena), .position(position), .pos_error(pos_error),
    .velocity(velocity), .vel_valid(vel_valid), .sample_err(sample_err), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic step(input bit s, input bit e, input logic signed [31:0] p, input bit pe);
    logic signed [31:0] d32;
    longint             d;
    sclr = s; ena = e; position = p; pos_error = pe;
    @(posedge clock);
    if (s) begin
      m_cnt = 0; m_run = 0; m_prev = 0; m_err_win = 0;
      p_vld = 0; p_err = 0; p_ovf = 0; p_vel = '0;
      m_vv = 0; m_serr = 0; m_ovf = 0; m_vel = '0;
    end else begin
      m_vv = p_vld;
      if (p_vld) begin
        m_vel  = p_vel;
        m_serr = p_err;
        m_ovf  = m_ovf | p_ovf;
      end
      p_vld = 0;
      if (e && m_cnt == PERIOD - 1) begin
        m_cnt = 0;
        if (m_run) begin
          d32   = p - m_prev;
          d     = longint'(d32);
          p_vld = 1;
          p_err = m_err_win | pe;
          p_ovf = (d > VMAX) || (d < VMIN);
          p_vel = (d > VMAX) ? VEL_W'(VMAX) : (d < VMIN) ? VEL_W'(VMIN) : VEL_W'(d);
        end
        m_prev    = p;
        m_run     = 1;
        m_err_win = 0;
      end else begin
        if (e) m_cnt++;
        if (pe) m_err_win = 1;
      end
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    step(1, 1, 32'sd1234, 1);
    step(1, 0, -32'sd77, 1);
    checks++; if (vel_valid !== 1'b0) begin errors++; $display("FAIL reset_vel_valid: got %b want 0", vel_valid); end
    checks++; if (velocity !== '0) begin errors++; $display("FAIL reset_velocity: got %0d want 0", velocity); end
    checks++; if (sample_err !== 1'b0) begin errors++; $display("FAIL reset_sample_err: got %b want 0", sample_err); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_constant();
    int pulses = 0;
    step(1, 0, 32'sd100, 0);
    for (int i = 1; i <= 22; i++) begin
      step(0, 1, 32'sd100, 0);
      checks++;
      if (vel_valid !== m_vv || velocity !== m_vel || sample_err !== m_serr || overflow !== m_ovf) begin
        errors++;
        $display("FAIL constant step %0d: got vv=%b vel=%0d serr=%b ovf=%b want vv=%b vel=%0d serr=%b ovf=%b",
                 i, vel_valid, velocity, sample_err, overflow, m_vv, m_vel, m_serr, m_ovf);
      end
      if (vel_valid === 1'b1) begin
        pulses++;
        checks++;
        if (i != 9 + 4 * (pulses - 1) || velocity !== '0) begin
          errors++; $display("FAIL constant_strobe: got step %0d vel %0d want step %0d vel 0", i, velocity, 9 + 4 * (pulses - 1));
        end
      end
    end
    checks++; if (pulses != 4) begin errors++; $display("FAIL constant_pulses: got %0d want 4", pulses); end
  endtask

  task automatic test_steady();
    logic signed [31:0] base;
    int pulses = 0;
    base = $urandom;
    step(1, 0, base, 0);
    for (int i = 1; i <= 26; i++) begin
      step(0, 1, base + 10 * ((i - 1) / PERIOD), 0);
      checks++;
      if (vel_valid !== m_vv || velocity !== m_vel || sample_err !== m_serr || overflow !== m_ovf) begin
        errors++;
        $display("FAIL steady step %0d: got vv=%b vel=%0d serr=%b ovf=%b want vv=%b vel=%0d serr=%b ovf=%b",
                 i, vel_valid, velocity, sample_err, overflow, m_vv, m_vel, m_serr, m_ovf);
      end
      if (vel_valid === 1'b1) begin
        pulses++;
        checks++;
        if (velocity !== 8'sd10 || sample_err !== 1'b0 || overflow !== 1'b0 || (i % PERIOD) != 1) begin
          errors++; $display("FAIL steady_value step %0d: got vel=%0d serr=%b ovf=%b want vel=10 serr=0 ovf=0", i, velocity, sample_err, overflow);
        end
      end
    end
    checks++; if (pulses != 5) begin errors++; $display("FAIL steady_pulses: got %0d want 5", pulses); end
  endtask

  task automatic test_wrap();
    step(1, 0, 32'sh7FFFFFF0, 0);
    for (int i = 1; i <= 10; i++) begin
      step(0, 1, (i <= 4) ? 32'sh7FFFFFF0 : 32'sh80000005, 0);
      checks++;
      if (vel_valid !== m_vv || velocity !== m_vel || overflow !== m_ovf) begin
        errors++;
        $display("FAIL wrap step %0d: got vv=%b vel=%0d ovf=%b want vv=%b vel=%0d ovf=%b", i, vel_valid, velocity, overflow, m_vv, m_vel, m_ovf);
      end
      if (i == 9) begin
        checks++;
        if (vel_valid !== 1'b1 || velocity !== 8'sd21 || overflow !== 1'b0) begin
          errors++; $display("FAIL wrap_value: got vv=%b vel=%0d ovf=%b want vv=1 vel=21 ovf=0", vel_valid, velocity, overflow);
        end
      end
    end
  endtask

  task automatic test_saturation();
    int sp[5] = '{0, 300, 0, 5, 5};
    int ev[3] = '{127, -128, 5};
    step(1, 0, 0, 0);
    for (int i = 1; i <= 18; i++) begin
      step(0, 1, sp[(i - 1) / PERIOD], 0);
      checks++;
      if (vel_valid !== m_vv || velocity !== m_vel || overflow !== m_ovf) begin
        errors++;
        $display("FAIL sat step %0d: got vv=%b vel=%0d ovf=%b want vv=%b vel=%0d ovf=%b", i, vel_valid, velocity, overflow, m_vv, m_vel, m_ovf);
      end
      if (i == 9 || i == 13 || i == 17) begin
        checks++;
        if (vel_valid !== 1'b1 || int'(velocity) != ev[(i - 9) / 4] || overflow !== 1'b1) begin
          errors++; $display("FAIL sat_value step %0d: got vv=%b vel=%0d ovf=%b want vv=1 vel=%0d ovf=1", i, vel_valid, velocity, overflow, ev[(i - 9) / 4]);
        end
      end
    end
  endtask

  task automatic test_error();
    int pulses = 0;
    bit want;
    step(1, 0, 32'sd50, 0);
    for (int i = 1; i <= 21; i++) begin
      step(0, 1, 32'sd50, (i == 6) || (i == 16));
      checks++;
      if (vel_valid !== m_vv || velocity !== m_vel || sample_err !== m_serr) begin
        errors++;
        $display("FAIL error step %0d: got vv=%b vel=%0d serr=%b want vv=%b vel=%0d serr=%b", i, vel_valid, velocity, sample_err, m_vv, m_vel, m_serr);
      end
      if (vel_valid === 1'b1) begin
        pulses++;
        want = (i == 9) || (i == 17);
        checks++;
        if (sample_err !== want) begin
          errors++; $display("FAIL error_flag step %0d: got %b want %b", i, sample_err, want);
        end
      end
    end
    checks++; if (pulses != 4) begin errors++; $display("FAIL error_pulses: got %0d want 4", pulses); end
  endtask

  task automatic test_sclr();
    int pulses = 0;
    step(1, 0, 0, 0);
    for (int i = 1; i <= 34; i++) begin
      step((i == 11) || (i == 23), 1, 50 * i, (i == 10) || (i == 22));
      checks++;
      if (vel_valid !== m_vv || velocity !== m_vel || sample_err !== m_serr || overflow !== m_ovf) begin
        errors++;
        $display("FAIL sclr step %0d: got vv=%b vel=%0d serr=%b ovf=%b want vv=%b vel=%0d serr=%b ovf=%b",
                 i, vel_valid, velocity, sample_err, overflow, m_vv, m_vel, m_serr, m_ovf);
      end
      if (i == 11 || i == 23) begin
        checks++;
        if (vel_valid !== 1'b0 || velocity !== '0 || sample_err !== 1'b0 || overflow !== 1'b0) begin
          errors++; $display("FAIL sclr_clear step %0d: got vv=%b vel=%0d serr=%b ovf=%b want all 0", i, vel_valid, velocity, sample_err, overflow);
        end
      end
      if (i == 24) begin
        checks++;
        if (vel_valid !== 1'b0) begin errors++; $display("FAIL sclr_inflight: got vv=%b want 0", vel_valid); end
      end
      if (i > 11 && vel_valid === 1'b1) pulses++;
    end
    checks++; if (pulses != 2) begin errors++; $display("FAIL sclr_pulses: got %0d want 2", pulses); end
  endtask

  task automatic test_inflight();
    step(1, 0, 0, 0);
    for (int i = 1; i <= 18; i++) begin
      step(0, (i <= 8) || (i >= 13), 3 * i, 0);
      checks++;
      if (vel_valid !== m_vv || velocity !== m_vel || overflow !== m_ovf) begin
        errors++;
        $display("FAIL inflight step %0d: got vv=%b vel=%0d ovf=%b want vv=%b vel=%0d ovf=%b", i, vel_valid, velocity, overflow, m_vv, m_vel, m_ovf);
      end
      if (i == 9) begin
        checks++;
        if (vel_valid !== 1'b1 || velocity !== 8'sd12) begin
          errors++; $display("FAIL inflight_value: got vv=%b vel=%0d want vv=1 vel=12", vel_valid, velocity);
        end
      end
    end
  endtask

  task automatic test_random();
    logic signed [31:0] pos;
    pos = $urandom;
    step(1, 0, pos, 0);
    for (int i = 1; i <= 600; i++) begin
      if ($urandom_range(0, 19) == 0) pos = pos + int'($urandom_range(0, 1000)) - 500;
      else                            pos = pos + int'($urandom_range(0, 20)) - 10;
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, pos, $urandom_range(0, 15) == 0);
      checks++;
      if (vel_valid !== m_vv || velocity !== m_vel || sample_err !== m_serr || overflow !== m_ovf) begin
        errors++;
        $display("FAIL random step %0d: got vv=%b vel=%0d serr=%b ovf=%b want vv=%b vel=%0d serr=%b ovf=%b",
                 i, vel_valid, velocity, sample_err, overflow, m_vv, m_vel, m_serr, m_ovf);
      end
    end
  endtask

  initial begin
    sclr = 1'b1; ena = 1'b0; position = '0; pos_error = 1'b0;
    test_reset();
    test_constant();
    test_steady();
    test_wrap();
    test_saturation();
    test_error();
    test_sclr();
    test_inflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
